// File: rtl/axis_pipe_skid_rx.sv
// axis_pipe_skid_rx: long-haul AXI-Stream link with the receive skid FIFO built in.
// Forward beats ride N_STAGES free-running registers (no per-stage stall);
// tready returns through N_STAGES registers as an almost-full credit, and the
// receive FIFO is sized to hold every beat still in flight when the sink stalls.
// Optional feature: define AXIS_PIPE_SKID_TLAST_EN to carry tlast with the data.
module axis_pipe_skid_rx #(
  parameter int N_STAGES   = 4,
  parameter int DATA_BITS  = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [DATA_BITS-1:0] s_axis_tdata,
`ifdef AXIS_PIPE_SKID_TLAST_EN
  input  logic                 s_axis_tlast,
  output logic                 m_axis_tlast,
`endif
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [DATA_BITS-1:0] m_axis_tdata
);

  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int CW     = PW + 1;
  // Throttle point: leaves room for the beats already in the forward pipe
  // plus those accepted while the deasserted ready travels back.
  localparam int THRESH = FIFO_DEPTH - 2*N_STAGES;

  if (N_STAGES < 1) begin : g_bad_stages
    $error("axis_pipe_skid_rx: N_STAGES must be >= 1");
  end
  if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FIFO_DEPTH < 2*N_STAGES + 2) begin : g_bad_depth
    $error("axis_pipe_skid_rx: FIFO_DEPTH must be a power of two >= 2*N_STAGES+2");
  end

  typedef struct packed {
`ifdef AXIS_PIPE_SKID_TLAST_EN
    logic                 last;
`endif
    logic [DATA_BITS-1:0] data;
  } beat_t;

  // ---------------------------------------------------------------- forward
  logic                accept;
  beat_t               s_beat;
  logic [N_STAGES-1:0] vld_pipe;
  logic [N_STAGES-1:0] vld_in;
  beat_t               dat_pipe [N_STAGES];
  beat_t               dat_in   [N_STAGES];

  // ----------------------------------------------------------------- return
  logic                below_thresh;
  logic [N_STAGES-1:0] rdy_pipe;
  logic [N_STAGES-1:0] rdy_in;

  // ------------------------------------------------------------------- FIFO
  beat_t               mem [FIFO_DEPTH];
  beat_t               head;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count;
  logic                wr_en;
  logic                rd_en;

  assign accept = s_axis_tvalid & s_axis_tready;

  // Pack the source side into one beat so data and tlast share every stage.
  always_comb begin
    s_beat      = '0;
    s_beat.data = s_axis_tdata;
`ifdef AXIS_PIPE_SKID_TLAST_EN
    s_beat.last = s_axis_tlast;
`endif
  end

  // Stage k input: the source for stage 0, otherwise the previous stage.
  for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign vld_in[k] = accept;
      assign dat_in[k] = s_beat;
      assign rdy_in[k] = below_thresh;
    end else begin : g_link
      assign vld_in[k] = vld_pipe[k-1];
      assign dat_in[k] = dat_pipe[k-1];
      assign rdy_in[k] = rdy_pipe[k-1];
    end

    // Data stages load only under a valid beat, never reset, never stall.
    always_ff @(posedge aclk) begin
      if (vld_in[k]) dat_pipe[k] <= dat_in[k];
    end
  end

  // Forward valid shift register; cleared so no stale beat survives reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) vld_pipe <= '0;
    else          vld_pipe <= vld_in;
  end

  // Return credit shift register; reset to 0 so tready starts low.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rdy_pipe <= '0;
    else          rdy_pipe <= rdy_in;
  end

  assign below_thresh  = (count < CW'(THRESH));
  assign s_axis_tready = rdy_pipe[N_STAGES-1];

  // Writes are never gated by full: the threshold sizing makes overflow
  // impossible as long as the source honours tready.
  assign wr_en         = vld_pipe[N_STAGES-1];
  assign m_axis_tvalid = (count != '0);
  assign rd_en         = m_axis_tvalid & m_axis_tready;

  // Storage array; written only, no reset needed for data.
  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_ptr] <= dat_pipe[N_STAGES-1];
  end

  // Pointers wrap naturally; count tracks occupancy (write and read together
  // leave it unchanged while both pointers advance).
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

  // Head of FIFO drives the sink; no same-cycle bypass from the write port.
  assign head         = mem[rd_ptr];
  assign m_axis_tdata = head.data;
`ifdef AXIS_PIPE_SKID_TLAST_EN
  assign m_axis_tlast = head.last;
`endif

endmodule

// File: tb/tb_axis_pipe_skid_rx.sv
// Scoreboard bench for axis_pipe_skid_rx: the monitor keeps a queue of
// accepted beats and a beat-level occupancy model (a beat enters the FIFO
// N edges after acceptance and leaves on a sink handshake).
`timescale 1ns/1ps
module tb_axis_pipe_skid_rx;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int FD = 16;

  logic          aclk     = 1'b0;
  logic          aresetn  = 1'b1;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] s_tdata  = '0;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [DW-1:0] m_tdata;
  logic          s_tlast  = 1'b0;
`ifdef AXIS_PIPE_SKID_TLAST_EN
  logic          m_tlast;
`endif

  axis_pipe_skid_rx #(.N_STAGES(N), .DATA_BITS(DW), .FIFO_DEPTH(FD)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
`ifdef AXIS_PIPE_SKID_TLAST_EN
    .s_axis_tlast  (s_tlast),
    .m_axis_tlast  (m_tlast),
`endif
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [DW-1:0] d; logic l; } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          occ    = 0;
  int          n_acc  = 0;
  int          n_pop  = 0;
  int          pend_q[$];
  exp_t        exp_q[$];
  exp_t        e;
  logic [DW-1:0] seq = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  always @(posedge aclk) cyc <= cyc + 1;

  // Monitor: sample between edges; any handshake seen here completes at the next edge.
  initial forever begin
    @(negedge aclk);
    if (!aresetn) begin
      exp_q.delete();
      pend_q.delete();
      occ = 0;
    end else begin
      while (pend_q.size() > 0 && pend_q[0] + N <= cyc) begin
        void'(pend_q.pop_front());
        occ++;
      end
      chk("occupancy_bound", occ <= FD, 1);
      chk("m_tvalid", m_tvalid, occ > 0);
      if (m_tvalid && m_tready) begin
        n_pop++;
        if (occ > 0) occ--;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_underflow: got beat %0h expected none", m_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("m_tdata", m_tdata, e.d);
`ifdef AXIS_PIPE_SKID_TLAST_EN
          chk("m_tlast", m_tlast, e.l);
`endif
        end
      end
      if (s_tvalid && s_tready) begin
        exp_q.push_back('{d: s_tdata, l: s_tlast});
        pend_q.push_back(cyc + 1);
        n_acc++;
      end
    end
  end

  // One cycle of source/sink drive; the data counter advances on acceptance.
  task automatic step(input bit v, input bit mr);
    bit acc;
    @(negedge aclk);
    acc = s_tvalid && s_tready;
    @(posedge aclk);
    #1;
    if (acc) seq = seq + 1;
    s_tvalid = v;
    s_tdata  = seq;
    s_tlast  = (seq % 3 == 2);
    m_tready = mr;
  endtask

  task automatic do_reset();
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    #1;
    chk("rst_async_m_tvalid", m_tvalid, 0);
    chk("rst_async_s_tready", s_tready, 0);
    repeat (5) begin
      @(posedge aclk); #1;
      chk("rst_s_tready", s_tready, 0);
      chk("rst_m_tvalid", m_tvalid, 0);
    end
    aresetn = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge aclk); #1;
      chk("tready_rise", s_tready, k == N);
      chk("post_rst_m_tvalid", m_tvalid, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    int a0, p0, guard;
    #2;
    do_reset();

    // Single beat driven just after edge t, visible from edge t+5 for one cycle.
    s_tvalid = 1'b1; s_tdata = 32'hA5A50001; s_tlast = 1'b0; m_tready = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge aclk); #1;
      if (k == 1) s_tvalid = 1'b0;
      chk("single_vld", m_tvalid, k == 5);
      if (k == 5) chk("single_data", m_tdata, 32'hA5A50001);
    end

    // Throughput: both sides ready, 100 beats.
    a0 = n_acc; p0 = n_pop;
    repeat (100) step(1, 1);
    repeat (12) step(0, 1);
    chk("tp_accepts", n_acc - a0, 100);
    chk("tp_pops", n_pop - p0, 100);

    // Backpressure: sink stalled while the source streams.
    repeat (40) step(1, 0);
    chk("bp_tready_low", s_tready, 0);
    chk("bp_m_tvalid", m_tvalid, 1);
    repeat (40) step(1, 1);
    repeat (30) step(0, 1);
    chk("bp_drain_empty", exp_q.size(), 0);

    // Random stalls: 70% source valid, 20% sink ready, 2000 beats.
    a0 = n_acc; guard = 0;
    while (n_acc - a0 < 2000 && guard < 40000) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2);
      guard++;
    end
    chk("rand_budget", guard < 40000, 1);
    repeat (60) step(0, 1);
    chk("rand_drain_empty", exp_q.size(), 0);

    // Mid-stream reset with beats in the pipe and the FIFO.
    repeat (10) step(1, 0);
    chk("mid_pre_vld", m_tvalid, 1);
    do_reset();
    p0 = n_pop;
    repeat (10) step(0, 1);
    chk("mid_no_stale", n_pop - p0, 0);
    repeat (20) step(1, 1);
    repeat (12) step(0, 1);
    chk("mid_resume_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
